// File: rtl/frame_buffer_pingpong_ctrl_if.sv
// Bundle of capture, RAM-write and reader handshake signals for the ping-pong frame controller.
interface frame_buffer_pingpong_ctrl_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned CNT_W  = 8
);
  logic              run;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_en;
  logic              frame_done;
  logic [ADDR_W:0]   mem_wr_addr;
  logic              mem_wr_data;
  logic              mem_wr_en;
  logic              rd_req;
  logic              rd_release;
  logic              rd_grant;
  logic              rd_bank;
  logic              frame_ready;
  logic [CNT_W-1:0]  frame_count;
  logic [CNT_W-1:0]  drop_count;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output run, wr_addr, wr_data, wr_en, frame_done, rd_req, rd_release,
    input  mem_wr_addr, mem_wr_data, mem_wr_en, rd_grant, rd_bank, frame_ready,
           frame_count, drop_count, err_count
  );

  modport slave (
    input  run, wr_addr, wr_data, wr_en, frame_done, rd_req, rd_release,
    output mem_wr_addr, mem_wr_data, mem_wr_en, rd_grant, rd_bank, frame_ready,
           frame_count, drop_count, err_count
  );
endinterface

// File: rtl/frame_buffer_pingpong_ctrl.sv
// Steers captured frames into two RAM banks, publishes complete frames to one reader
// via request/grant/release, and keeps frame/drop/error statistics.
module frame_buffer_pingpong_ctrl #(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned CNT_W        = 8
) (
  input logic                         cam_pclk,
  input logic                         nreset,
  frame_buffer_pingpong_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACTIVE} state_t;
  typedef enum logic [1:0] {BK_FREE, BK_READY, BK_READING} bank_st_t;

  localparam int unsigned       PCNT_W    = ADDR_W + 1;
  localparam logic [PCNT_W-1:0] FRAME_LEN = PCNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t             state;
  bank_st_t           other_st;
  logic               wr_bank;
  logic [PCNT_W-1:0]  pix_cnt;
  logic               mem_wr_en_q;
  logic               mem_wr_data_q;
  logic [ADDR_W:0]    mem_wr_addr_q;
  logic               rd_grant_q;
  logic               rd_bank_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic               release_ok;
  logic               grant_ok;
  logic               len_ok;
  bank_st_t           st_pre_end;
  logic [PCNT_W-1:0]  pix_len;
  logic [PCNT_W-1:0]  pix_restart;

  // Release, then grant, resolve first; frame end sees the resulting bank status.
  always_comb begin
    release_ok  = bus.rd_release && rd_grant_q;
    grant_ok    = bus.rd_req && !rd_grant_q && (other_st == BK_READY);
    st_pre_end  = other_st;
    if (release_ok) st_pre_end = BK_FREE;
    if (grant_ok)   st_pre_end = BK_READING;
    pix_len     = pix_cnt + PCNT_W'(bus.wr_en);
    pix_restart = PCNT_W'(bus.wr_en);
    len_ok      = (pix_len == FRAME_LEN);
  end

  always_ff @(posedge cam_pclk) begin
    if (!nreset) begin
      state         <= ST_IDLE;
      other_st      <= BK_FREE;
      wr_bank       <= 1'b0;
      pix_cnt       <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= 1'b0;
      mem_wr_addr_q <= '0;
      rd_grant_q    <= 1'b0;
      rd_bank_q     <= 1'b0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      mem_wr_en_q   <= bus.wr_en && (state == ST_ACTIVE);
      mem_wr_addr_q <= {wr_bank, bus.wr_addr};
      mem_wr_data_q <= bus.wr_data;
      other_st      <= st_pre_end;

      if (release_ok) rd_grant_q <= 1'b0;
      if (grant_ok) begin
        rd_grant_q <= 1'b1;
        rd_bank_q  <= ~wr_bank;
      end

      case (state)
        ST_IDLE: if (bus.run) state <= ST_SYNC;
        ST_SYNC: begin
          if (!bus.run) begin
            state <= ST_IDLE;
          end else if (bus.frame_done) begin
            state   <= ST_ACTIVE;
            pix_cnt <= pix_restart;
          end
        end
        ST_ACTIVE: begin
          if (!bus.run) begin
            state <= ST_IDLE;
          end else if (bus.frame_done) begin
            pix_cnt <= pix_restart;
            if (!len_ok) begin
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_ONE;
            end else begin
              case (st_pre_end)
                BK_FREE: begin
                  wr_bank     <= ~wr_bank;
                  other_st    <= BK_READY;
                  frame_cnt_q <= frame_cnt_q + CNT_ONE;
                end
                BK_READY: begin
                  wr_bank     <= ~wr_bank;
                  frame_cnt_q <= frame_cnt_q + CNT_ONE;
                  if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_ONE;
                end
                default: begin
                  if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_ONE;
                end
              endcase
            end
          end else begin
            pix_cnt <= pix_len;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.rd_grant    = rd_grant_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.frame_ready = (other_st == BK_READY);
  assign bus.frame_count = frame_cnt_q;
  assign bus.drop_count  = drop_cnt_q;
  assign bus.err_count   = err_cnt_q;
endmodule

// File: tb/tb_frame_buffer_pingpong_ctrl.sv
// Directed bench for the ping-pong frame controller with 64-pixel frames.
module tb_frame_buffer_pingpong_ctrl;
  localparam int unsigned FRAME_PIXELS = 64;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned CNT_W        = 8;

  logic cam_pclk = 1'b0;
  logic nreset   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  frame_buffer_pingpong_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  frame_buffer_pingpong_ctrl #(
    .FRAME_PIXELS(FRAME_PIXELS),
    .ADDR_W(ADDR_W),
    .CNT_W(CNT_W)
  ) dut (
    .cam_pclk(cam_pclk),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 cam_pclk = ~cam_pclk;

  typedef struct {
    int npix;
    bit req;
    bit rel;
    bit exp_we;
    bit exp_bank;
    int fc;
    int drop;
    int err;
    bit ready;
    bit grant;
    bit rbank;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge cam_pclk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int fc, input int drop, input int err,
                             input bit ready, input bit grant);
    check({tag, " frame_count"}, bus.frame_count, fc);
    check({tag, " drop_count"},  bus.drop_count,  drop);
    check({tag, " err_count"},   bus.err_count,   err);
    check({tag, " frame_ready"}, bus.frame_ready, ready);
    check({tag, " rd_grant"},    bus.rd_grant,    grant);
  endtask

  task automatic check_all_zero(input string tag);
    check_stats(tag, 0, 0, 0, 1'b0, 1'b0);
    check({tag, " mem_wr_en"},   bus.mem_wr_en,   0);
    check({tag, " mem_wr_addr"}, bus.mem_wr_addr, 0);
    check({tag, " mem_wr_data"}, bus.mem_wr_data, 0);
    check({tag, " rd_bank"},     bus.rd_bank,     0);
  endtask

  task automatic pixels(input int start, input int count, input bit exp_we, input bit exp_bank);
    logic [ADDR_W:0] ea;
    for (int i = start; i < start + count; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(i);
      bus.wr_data = i[0];
      tick();
      check("mem_wr_en", bus.mem_wr_en, exp_we);
      if (exp_we) begin
        ea = {exp_bank, ADDR_W'(i)};
        check("mem_wr_addr", bus.mem_wr_addr, ea);
        check("mem_wr_data", bus.mem_wr_data, i[0]);
      end
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic done_cycle();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    check("mem_wr_en idle", bus.mem_wr_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0; bus.wr_addr = '0; bus.wr_data = 1'b0; bus.wr_en = 1'b0;
    bus.frame_done = 1'b0; bus.rd_req = 1'b0; bus.rd_release = 1'b0;

    //               npix req rel we bank fc drop err rdy gnt rbank
    tbl[0] = '{64, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{64, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{64, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1, 0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{64, 1'b0, 1'b0, 1'b1, 1'b0, 3, 2, 0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{40, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2, 1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{64, 1'b0, 1'b0, 1'b1, 1'b1, 4, 3, 1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{64, 1'b1, 1'b0, 1'b1, 1'b0, 4, 4, 1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{64, 1'b0, 1'b1, 1'b1, 1'b0, 5, 4, 1, 1'b1, 1'b0, 1'b0};

    // Bring-up
    nreset = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    nreset = 1'b1;
    bus.run = 1'b1;
    tick();
    pixels(0, 64, 1'b0, 1'b0);
    done_cycle();
    check_stats("sync frame", 0, 0, 0, 1'b0, 1'b0);
    pixels(0, 64, 1'b1, 1'b0);
    done_cycle();
    check_stats("first frame", 1, 0, 0, 1'b1, 1'b0);

    // Handshake
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("grant rd_grant", bus.rd_grant, 1);
    check("grant rd_bank", bus.rd_bank, 0);
    check("grant frame_ready", bus.frame_ready, 0);
    pixels(0, 64, 1'b1, 1'b1);
    done_cycle();
    check_stats("reading drop", 1, 1, 0, 1'b0, 1'b1);
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
    check_stats("release", 1, 1, 0, 1'b0, 1'b0);
    pixels(0, 64, 1'b1, 1'b1);
    done_cycle();
    check_stats("after release", 2, 1, 0, 1'b1, 1'b0);

    // Fresh start for the table of frame-level vectors
    nreset = 1'b0;
    tick();
    check_all_zero("reset from ready");
    nreset = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      pixels(0, tbl[k].npix, tbl[k].exp_we, tbl[k].exp_bank);
      bus.rd_req     = tbl[k].req;
      bus.rd_release = tbl[k].rel;
      done_cycle();
      bus.rd_req     = 1'b0;
      bus.rd_release = 1'b0;
      check_stats($sformatf("vec%0d", k), tbl[k].fc, tbl[k].drop, tbl[k].err,
                  tbl[k].ready, tbl[k].grant);
      if (tbl[k].grant) check($sformatf("vec%0d rd_bank", k), bus.rd_bank, tbl[k].rbank);
    end

    // Grant, release, then a stray release
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("regrant rd_grant", bus.rd_grant, 1);
    check("regrant rd_bank", bus.rd_bank, 0);
    bus.rd_release = 1'b1;
    tick();
    check_stats("rel2", 5, 4, 1, 1'b0, 1'b0);
    tick();
    bus.rd_release = 1'b0;
    check_stats("stray release", 5, 4, 1, 1'b0, 1'b0);

    // Pending request is granted the cycle after the frame becomes ready
    bus.rd_req = 1'b1;
    pixels(0, 64, 1'b1, 1'b1);
    check("pending no early grant", bus.rd_grant, 0);
    done_cycle();
    check_stats("pending ready", 6, 4, 1, 1'b1, 1'b0);
    tick();
    bus.rd_req = 1'b0;
    check_stats("pending grant", 6, 4, 1, 1'b0, 1'b1);
    check("pending rd_bank", bus.rd_bank, 1);

    // run drops mid-frame
    pixels(0, 30, 1'b1, 1'b0);
    bus.run = 1'b0;
    tick();
    check("run off mem_wr_en", bus.mem_wr_en, 0);
    pixels(30, 34, 1'b0, 1'b0);
    done_cycle();
    check_stats("run off", 6, 4, 1, 1'b0, 1'b1);
    check("run off rd_bank", bus.rd_bank, 1);

    // Resync, then a frame whose last pixel coincides with frame_done
    bus.run = 1'b1;
    tick();
    pixels(0, 64, 1'b0, 1'b0);
    done_cycle();
    check_stats("resync", 6, 4, 1, 1'b0, 1'b1);
    pixels(0, 63, 1'b1, 1'b0);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(63); bus.wr_data = 1'b1; bus.frame_done = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.frame_done = 1'b0;
    check("coincide mem_wr_en", bus.mem_wr_en, 1);
    check("coincide mem_wr_addr", bus.mem_wr_addr, 63);
    check_stats("coincide", 6, 5, 1, 1'b0, 1'b1);

    // Reset while granted, with other inputs active
    bus.rd_req = 1'b1; bus.wr_en = 1'b1; bus.frame_done = 1'b1;
    nreset = 1'b0;
    tick();
    check_all_zero("reset in grant");
    bus.rd_req = 1'b0; bus.wr_en = 1'b0; bus.frame_done = 1'b0;
    nreset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
